update_apply: RTL and testbench
===============================

UPDATE_APPLY -- requirements
Module: update_apply

Interface
REQ-001 Parameter MVW, default 8: width of signed motion-vector components.
REQ-002 Parameter MV_MAX, default 63: candidate component saturation bound; legal range is [-MV_MAX, +MV_MAX].
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 uvec  input  6  update vector from the Update block: [2:0] = signed x offset, [5:3] = signed y offset (two's complement).
REQ-006 upd_en  output  1  one-cycle pulse that advances the Update block's LFSR to the next vector.
REQ-007 pred_x, pred_y  input  MVW each  signed predictor vector.
REQ-008 pred_valid / pred_ready  input / output  1 each  predictor handshake; a transfer occurs when both are high on a clock edge.
REQ-009 cand_x, cand_y  output  MVW each  signed candidate = predictor + update, saturated.
REQ-010 cand_idx  output  5  table index of the applied update vector.
REQ-011 cand_sat  output  1  high when either candidate component was saturated.
REQ-012 cand_bad  output  1  high when uvec was not a legal table entry.
REQ-013 cand_valid / cand_ready  output / input  1 each  candidate handshake.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and HOLD.
REQ-015 IDLE: pred_ready SHALL be 1. On a pred_valid transfer, the block SHALL capture pred_x, pred_y and uvec together and go to CALC.
REQ-016 CALC: the block SHALL register the candidate and flags, pulse upd_en for exactly this cycle, and go to HOLD; pred_ready SHALL be 0.
REQ-017 HOLD: cand_valid SHALL be 1 and all cand_* outputs SHALL be held stable. On cand_ready = 1 the block SHALL return to IDLE; pred_ready SHALL be 0.
REQ-018 Latency: cand_valid SHALL rise on the 2nd edge after the predictor transfer edge. With cand_ready tied high, throughput SHALL be one candidate per 3 cycles.
REQ-019 Arithmetic: offsets SHALL be sign-extended to MVW+1 bits and added at MVW+1 bits.
REQ-020 Each sum SHALL be clamped to ±MV_MAX, and cand_sat SHALL be set if either component clamps.
REQ-021 Legal x offsets are -3..3 and legal y offsets are -2..2, excluding (0,0), (-3,-2) and (3,-2).
REQ-022 Index map, x-major then y ascending: x=-3: y -1..2 -> 0..3; x=-2 -> 4..8; x=-1 -> 9..13; x=0 (y≠0) -> 14..17; x=1 -> 18..22; x=2 -> 23..27; x=3: y -1..2 -> 28..31.
REQ-023 For an illegal uvec (x=100b, y∉-2..2, or an excluded pair): cand_bad=1, cand_idx=0, and the candidate SHALL equal the predictor with zero offset, still saturated.
REQ-024 upd_en SHALL never be high outside CALC, so exactly one LFSR advance occurs per accepted predictor.
REQ-025 pred_valid in CALC or HOLD SHALL be ignored; the block SHALL NOT capture a new predictor until it has returned to IDLE.

Reset
REQ-026 With reset=0 at an edge: state<=IDLE, upd_en=0, cand_valid=0, cand_x=cand_y=0, cand_idx=0, cand_sat=0, cand_bad=0.
REQ-027 While reset=0, pred_ready SHALL be 0; it SHALL become 1 on the first edge after reset deasserts.
REQ-028 A reset asserted in CALC or HOLD SHALL abort the operation, drop the pending candidate, and suppress that cycle's upd_en.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, UVEC_W=6, IDX_W=5, and the legal offset bounds.
REQ-030 One sub-module, uvec_index_enc, SHALL implement the combinational uvec -> {idx, bad} mapping, so it is reusable and tested against the Update table.
REQ-031 Saturation logic SHALL be a function in the package, not a separate module.

Verification
REQ-032 pred=(10,-5), uvec=111101b (-3,-1), cand_ready=1 -> cand=(7,-6), idx=0, sat=0, bad=0, valid on 2nd edge, one upd_en pulse.
REQ-033 pred=(62,-62), uvec=010011b (3,2) -> cand=(63,-60), idx=31, sat=1.
REQ-034 pred=(-62,0), uvec=000101b (-3,0) -> cand=(-63,0), sat=1, idx=1.
REQ-035 uvec=000000b, then uvec=110101b -> bad=1, idx=0, cand=pred both times.
REQ-036 cand_ready held 0 for 5 cycles in HOLD, with pred_valid high throughout -> outputs stable, pred_ready=0, no extra upd_en; a cand_ready pulse leads to IDLE.
REQ-037 Reset driven low during CALC -> no upd_en that cycle, cand_valid=0, all outputs at reset values; pred_ready=1 on the first edge after release.
REQ-038 Exhaustive sweep of all 64 uvec codes through uvec_index_enc -> 32 legal codes map to unique idx 0..31, matching the Update table; 32 codes flag bad.

Source files
------------

// File: rtl/update_apply_pkg.sv
// Shared types, widths and helpers for the update_apply block and its encoder.
// Holds the FSM encoding, vector widths, legal offset bounds and the clamp function.
package update_apply_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int UVEC_W = 6;
  localparam int IDX_W  = 5;

  localparam int X_MIN = -3;
  localparam int X_MAX = 3;
  localparam int Y_MIN = -2;
  localparam int Y_MAX = 2;

  // Clamp a signed value into [-lim, +lim]; callers compare in/out to detect saturation.
  function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] v, input int lim);
    logic signed [31:0] r;
    r = v;
    if (v > lim) begin
      r = lim;
    end else if (v < -lim) begin
      r = -lim;
    end
    return r;
  endfunction

endpackage

// File: rtl/update_apply_if.sv
// Predictor, update-vector and candidate signals of update_apply bundled as one interface.
// The slave modport is the block itself; the master modport is its environment.
interface update_apply_if
  import update_apply_pkg::*;
#(
  parameter int MVW = 8
);

  logic        [UVEC_W-1:0] uvec;
  logic                     upd_en;
  logic signed [MVW-1:0]    pred_x;
  logic signed [MVW-1:0]    pred_y;
  logic                     pred_valid;
  logic                     pred_ready;
  logic signed [MVW-1:0]    cand_x;
  logic signed [MVW-1:0]    cand_y;
  logic        [IDX_W-1:0]  cand_idx;
  logic                     cand_sat;
  logic                     cand_bad;
  logic                     cand_valid;
  logic                     cand_ready;

  modport slave (
    input  uvec, pred_x, pred_y, pred_valid, cand_ready,
    output upd_en, pred_ready, cand_x, cand_y, cand_idx, cand_sat, cand_bad, cand_valid
  );

  modport master (
    output uvec, pred_x, pred_y, pred_valid, cand_ready,
    input  upd_en, pred_ready, cand_x, cand_y, cand_idx, cand_sat, cand_bad, cand_valid
  );

endinterface

// File: rtl/uvec_index_enc.sv
// Combinational map from a 6-bit update vector to its table index and an illegal-code flag.
// Table order is x-major, y ascending, skipping (0,0), (-3,-2) and (3,-2).
module uvec_index_enc
  import update_apply_pkg::*;
(
  input  logic [UVEC_W-1:0] uvec,
  output logic [IDX_W-1:0]  idx,
  output logic              bad
);

  int   xi;
  int   yi;
  int   base;
  int   off;
  logic legal;

  // Each x column starts at a fixed base; the x=0 and x=+-3 columns are short by one entry.
  always_comb begin
    xi    = int'($signed(uvec[2:0]));
    yi    = int'($signed(uvec[5:3]));
    base  = 0;
    off   = 0;
    legal = 1'b0;

    case (xi)
      -3:      base = 0;
      -2:      base = 4;
      -1:      base = 9;
      0:       base = 14;
      1:       base = 18;
      2:       base = 23;
      3:       base = 28;
      default: base = 0;
    endcase

    if (xi == X_MIN || xi == X_MAX) begin
      off = yi + 1;
    end else if (xi == 0 && yi > 0) begin
      off = yi + 1;
    end else begin
      off = yi - Y_MIN;
    end

    legal = (xi >= X_MIN) && (xi <= X_MAX) && (yi >= Y_MIN) && (yi <= Y_MAX) &&
            !(xi == 0 && yi == 0) && !((xi == X_MIN || xi == X_MAX) && yi == Y_MIN);

    idx = legal ? IDX_W'(base + off) : '0;
    bad = !legal;
  end

endmodule

// File: rtl/update_apply.sv
// Applies an update vector to a predictor to produce a saturated candidate motion vector.
// Three-state handshake FSM: accept predictor, compute and advance the LFSR, hold result.
module update_apply
  import update_apply_pkg::*;
#(
  parameter int MVW    = 8,
  parameter int MV_MAX = 63
) (
  input logic          clk,
  input logic          reset,
  update_apply_if.slave bus
);

  state_t state;
  state_t state_next;

  logic                    ready_q;
  logic signed [MVW-1:0]   px;
  logic signed [MVW-1:0]   py;
  logic        [UVEC_W-1:0] uv;

  logic        [IDX_W-1:0] enc_idx;
  logic                    enc_bad;
  logic signed [2:0]       ox;
  logic signed [2:0]       oy;
  logic signed [MVW:0]     sum_x;
  logic signed [MVW:0]     sum_y;
  logic signed [31:0]      clamp_x;
  logic signed [31:0]      clamp_y;
  logic                    sat_x;
  logic                    sat_y;

  logic signed [MVW-1:0]   cand_x_q;
  logic signed [MVW-1:0]   cand_y_q;
  logic        [IDX_W-1:0] cand_idx_q;
  logic                    cand_sat_q;
  logic                    cand_bad_q;

  uvec_index_enc u_enc (
    .uvec (uv),
    .idx  (enc_idx),
    .bad  (enc_bad)
  );

  // Illegal codes contribute a zero offset but the predictor is still clamped.
  always_comb begin
    ox      = enc_bad ? 3'sd0 : $signed(uv[2:0]);
    oy      = enc_bad ? 3'sd0 : $signed(uv[5:3]);
    sum_x   = {px[MVW-1], px} + {{(MVW-2){ox[2]}}, ox};
    sum_y   = {py[MVW-1], py} + {{(MVW-2){oy[2]}}, oy};
    clamp_x = sat_clamp(32'(sum_x), MV_MAX);
    clamp_y = sat_clamp(32'(sum_y), MV_MAX);
    sat_x   = (clamp_x != 32'(sum_x));
    sat_y   = (clamp_y != 32'(sum_y));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.pred_valid && ready_q) state_next = CALC;
      CALC:    state_next = HOLD;
      HOLD:    if (bus.cand_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ready is registered so it stays low throughout reset and rises one edge after release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      px         <= '0;
      py         <= '0;
      uv         <= '0;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      cand_idx_q <= '0;
      cand_sat_q <= 1'b0;
      cand_bad_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == IDLE);
      if (state == IDLE && bus.pred_valid && ready_q) begin
        px <= bus.pred_x;
        py <= bus.pred_y;
        uv <= bus.uvec;
      end
      if (state == CALC) begin
        cand_x_q   <= MVW'(clamp_x);
        cand_y_q   <= MVW'(clamp_y);
        cand_idx_q <= enc_idx;
        cand_sat_q <= sat_x || sat_y;
        cand_bad_q <= enc_bad;
      end
    end
  end

  assign bus.upd_en     = (state == CALC) && reset;
  assign bus.pred_ready = ready_q;
  assign bus.cand_valid = (state == HOLD) && reset;
  assign bus.cand_x     = cand_x_q;
  assign bus.cand_y     = cand_y_q;
  assign bus.cand_idx   = cand_idx_q;
  assign bus.cand_sat   = cand_sat_q;
  assign bus.cand_bad   = cand_bad_q;

endmodule

// File: tb/tb_update_apply.sv
// Directed self-checking bench for update_apply and an exhaustive sweep of uvec_index_enc.
module tb_update_apply;
  import update_apply_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  update_apply_if #(.MVW(8)) bus ();

  update_apply #(.MVW(8), .MV_MAX(63)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [5:0] enc_uvec;
  logic [4:0] enc_idx;
  logic       enc_bad;

  uvec_index_enc u_enc (
    .uvec (enc_uvec),
    .idx  (enc_idx),
    .bad  (enc_bad)
  );

  int   checks = 0;
  int   errors = 0;
  int   exp_idx [64];
  logic exp_bad [64];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference table built by walking the legal offsets in table order.
  task automatic buildTable();
    int n;
    logic [2:0] xb;
    logic [2:0] yb;
    for (int c = 0; c < 64; c++) begin
      exp_bad[c] = 1'b1;
      exp_idx[c] = 0;
    end
    n = 0;
    for (int x = -3; x <= 3; x++) begin
      for (int y = -2; y <= 2; y++) begin
        if (!(x == 0 && y == 0) && !((x == -3 || x == 3) && y == -2)) begin
          xb = 3'(x);
          yb = 3'(y);
          exp_bad[{yb, xb}] = 1'b0;
          exp_idx[{yb, xb}] = n;
          n++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input int px, input int py, input logic [5:0] uv,
                               input int ex, input int ey, input int eidx, input int esat, input int ebad);
    bit seen;
    int edges;
    int pulses;
    @(negedge clk);
    bus.pred_x     = 8'(px);
    bus.pred_y     = 8'(py);
    bus.uvec       = uv;
    bus.pred_valid = 1'b1;
    bus.cand_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.pred_ready) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, "_ready"}, 32'(seen), 1);
    @(posedge clk);
    #1;
    bus.pred_valid = 1'b0;
    bus.uvec       = ~uv;
    bus.pred_x     = 8'(px + 1);
    pulses = int'(bus.upd_en);
    edges  = 0;
    while (!bus.cand_valid && edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
      pulses += int'(bus.upd_en);
    end
    checkOutput({tag, "_latency"}, 32'(edges), 1);
    checkOutput({tag, "_upd"}, 32'(pulses), 1);
    checkOutput({tag, "_x"}, 32'(bus.cand_x), 32'(ex));
    checkOutput({tag, "_y"}, 32'(bus.cand_y), 32'(ey));
    checkOutput({tag, "_idx"}, 32'(bus.cand_idx), 32'(eidx));
    checkOutput({tag, "_sat"}, 32'(bus.cand_sat), 32'(esat));
    checkOutput({tag, "_bad"}, 32'(bus.cand_bad), 32'(ebad));
    @(posedge clk);
    #1;
    checkOutput({tag, "_idle_ready"}, 32'(bus.pred_ready), 1);
    checkOutput({tag, "_idle_valid"}, 32'(bus.cand_valid), 0);
  endtask

  initial begin
    bit stable;
    int pulses;
    int valids;
    int legal_cnt;
    logic [31:0] seen_mask;

    bus.pred_x     = '0;
    bus.pred_y     = '0;
    bus.uvec       = '0;
    bus.pred_valid = 1'b0;
    bus.cand_ready = 1'b1;
    enc_uvec       = '0;
    buildTable();

    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(bus.pred_ready), 0);
    checkOutput("rst_valid", 32'(bus.cand_valid), 0);
    checkOutput("rst_upd", 32'(bus.upd_en), 0);
    checkOutput("rst_x", 32'(bus.cand_x), 0);
    checkOutput("rst_idx", 32'(bus.cand_idx), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rel_ready_early", 32'(bus.pred_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("rel_ready", 32'(bus.pred_ready), 1);

    // Directed vectors
    applyStimulus("basic",  10,  -5, 6'b111101,   7,  -6,  0, 0, 0);
    applyStimulus("satpos", 62, -62, 6'b010011,  63, -60, 31, 1, 0);
    applyStimulus("satneg", -62,  0, 6'b000101, -63,   0,  1, 1, 0);
    applyStimulus("mid",     0,   0, 6'b110010,   2,  -2, 23, 0, 0);
    applyStimulus("saty",    0,  62, 6'b010000,   0,  63, 17, 1, 0);
    applyStimulus("bad00",   5,  -7, 6'b000000,   5,  -7,  0, 0, 1);
    applyStimulus("badex",   5,  -7, 6'b110101,   5,  -7,  0, 0, 1);
    applyStimulus("bady3",  -1,   2, 6'b011001,  -1,   2,  0, 0, 1);
    applyStimulus("badsat", -64, 20, 6'b000000, -63,  20,  0, 1, 1);

    // Backpressure in HOLD with pred_valid held high
    @(negedge clk);
    bus.pred_x     = 8'(20);
    bus.pred_y     = 8'(30);
    bus.uvec       = 6'b001001;
    bus.pred_valid = 1'b1;
    bus.cand_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("hold_valid", 32'(bus.cand_valid), 1);
    checkOutput("hold_x", 32'(bus.cand_x), 21);
    checkOutput("hold_y", 32'(bus.cand_y), 31);
    checkOutput("hold_idx", 32'(bus.cand_idx), 21);
    bus.pred_x = 8'(-40);
    bus.uvec   = 6'b111101;
    stable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      pulses += int'(bus.upd_en);
      if (!bus.cand_valid || bus.pred_ready || bus.cand_x != 8'(21) || bus.cand_y != 8'(31) ||
          bus.cand_idx != 5'd21)
        stable = 1'b0;
    end
    checkOutput("hold_stable", 32'(stable), 1);
    checkOutput("hold_upd", 32'(pulses), 0);
    @(negedge clk);
    bus.cand_ready = 1'b1;
    bus.pred_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("hold_exit_ready", 32'(bus.pred_ready), 1);
    checkOutput("hold_exit_valid", 32'(bus.cand_valid), 0);

    // Reset during CALC
    @(negedge clk);
    bus.pred_x     = 8'(1);
    bus.pred_y     = 8'(1);
    bus.uvec       = 6'b111101;
    bus.pred_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.pred_valid = 1'b0;
    checkOutput("calc_upd", 32'(bus.upd_en), 1);
    reset = 1'b0;
    #1;
    checkOutput("abort_upd", 32'(bus.upd_en), 0);
    @(posedge clk);
    #1;
    checkOutput("abort_valid", 32'(bus.cand_valid), 0);
    checkOutput("abort_x", 32'(bus.cand_x), 0);
    checkOutput("abort_y", 32'(bus.cand_y), 0);
    checkOutput("abort_idx", 32'(bus.cand_idx), 0);
    checkOutput("abort_sat", 32'(bus.cand_sat), 0);
    checkOutput("abort_bad", 32'(bus.cand_bad), 0);
    checkOutput("abort_ready", 32'(bus.pred_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("abort_upd2", 32'(bus.upd_en), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_rel_early", 32'(bus.pred_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("abort_rel_ready", 32'(bus.pred_ready), 1);

    // Back-to-back throughput: one candidate every 3 cycles
    @(negedge clk);
    bus.pred_x     = 8'(0);
    bus.pred_y     = 8'(0);
    bus.uvec       = 6'b110010;
    bus.pred_valid = 1'b1;
    bus.cand_ready = 1'b1;
    pulses = 0;
    valids = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      pulses += int'(bus.upd_en);
      valids += int'(bus.cand_valid);
    end
    bus.pred_valid = 1'b0;
    checkOutput("tput_upd", 32'(pulses), 3);
    checkOutput("tput_valid", 32'(valids), 3);

    // Exhaustive encoder sweep
    legal_cnt = 0;
    seen_mask = '0;
    for (int c = 0; c < 64; c++) begin
      enc_uvec = 6'(c);
      #1;
      checkOutput($sformatf("enc_bad_%0d", c), 32'(enc_bad), 32'(exp_bad[c]));
      checkOutput($sformatf("enc_idx_%0d", c), 32'(enc_idx), 32'(exp_idx[c]));
      if (!enc_bad) begin
        legal_cnt++;
        seen_mask[enc_idx] = 1'b1;
      end
    end
    checkOutput("enc_legal_count", 32'(legal_cnt), 32);
    checkOutput("enc_unique", seen_mask, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
